// File: rtl/param_mem_pkg.sv
// Shared types and width helpers for the round-robin shared scratch memory.
package param_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a channel index / round-robin pointer.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        return clog2(num_ch);
    endfunction

    // Width of a storage word index.
    function automatic int unsigned idx_w(input int unsigned depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter
    import param_mem_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_gnt_idx,
    output logic          o_any
);

    // Scan channels ptr, ptr+1, ... mod N and grant the first one requesting.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!o_any && (j == ((32'(i_ptr) + k) % N)) && i_req[j]) begin
                    o_gnt[j]  = 1'b1;
                    o_gnt_idx = PW'(j);
                    o_any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/param_mem_rr_port.sv
// Shared DEPTH x DATA_WIDTH scratch memory with NUM_CH round-robin requesters,
// self-clearing init after reset and one-cycle registered responses.
module param_mem_rr_port
    import param_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]            req_ready,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         ready
);

    localparam int unsigned CH_W  = ch_w(NUM_CH);
    localparam int unsigned IDX_W = idx_w(DEPTH);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_init_cnt;
    logic                    w_init_last;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [NUM_CH-1:0]       w_req_run;
    logic [NUM_CH-1:0]       w_gnt;
    logic [CH_W-1:0]         w_gnt_idx;
    logic                    w_acc;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_we;
    logic                    w_in_range;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [NUM_CH-1:0]       r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_err;
    logic                    r_ready;

    assign w_init_last = (r_init_cnt == IDX_W'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state: INIT walks every word once, then RUN until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Init word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  r_init_cnt <= '0;
        else if (r_state == ST_INIT && !w_init_last) r_init_cnt <= r_init_cnt + 1'b1;
    end

    // Requests are only visible to the arbiter once init has finished.
    assign w_req_run = (r_state == ST_RUN) ? req_valid : '0;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .i_req     (w_req_run),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_acc)
    );

    assign req_ready = w_gnt;

    // Mux the winning channel's request fields.
    always_comb begin
        w_addr     = req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata    = req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        w_we       = req_we[w_gnt_idx];
        w_in_range = (64'(w_addr) < 64'(DEPTH));
        w_idx      = w_addr[IDX_W-1:0];
    end

    // Round-robin pointer moves past the channel just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_acc) begin
            r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Storage: cleared word-by-word during INIT, written by in-range accepted writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_acc && w_we && w_in_range) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    // Response pipeline: one-cycle completion pulse for the accepted channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_acc ? w_gnt : '0;
            r_rsp_err   <= w_acc && !w_in_range;
            r_rsp_data  <= (w_acc && !w_we && w_in_range) ? r_mem[w_idx] : '0;
        end
    end

    // Ready flag rises together with the first RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ready <= 1'b0;
        else        r_ready <= (w_state_nxt == ST_RUN);
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign ready     = r_ready;

endmodule

// File: tb/tb_param_mem_rr_port.sv
// Directed self-checking bench for param_mem_rr_port.
module tb_param_mem_rr_port;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned NCH   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              ready;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        seen_busy;

    logic [DW-1:0] exp_d [4];
    logic          exp_e [4];

    param_mem_rr_port #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NUM_CH     (NCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned ch, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[ch]          = 1'b1;
        req_we[ch]             = we;
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic chk_rsp(input string tag, input logic [NCH-1:0] v,
                           input logic [DW-1:0] d, input logic e);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
        chk({tag, "_data"},  64'(rsp_data),  64'(d));
        chk({tag, "_err"},   64'(rsp_err),   64'(e));
    endtask

    initial begin
        reset     = 1'b0;
        idle();
        req_addr  = '0;
        req_wdata = '0;
        req_valid = 4'hF;
        #12;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk_rsp("rst", 4'b0000, 16'h0000, 1'b0);

        // Release reset, requests held valid throughout INIT must not be granted.
        tick();
        reset     = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 511; i++) begin
            tick();
            seen_busy = seen_busy | (ready !== 1'b0) | (req_ready !== 4'b0000);
        end
        idle();
        chk("init_hold_511", 64'(seen_busy), 64'd0);
        tick();
        chk("init_ready_512", 64'(ready), 64'd1);
        chk_rsp("init_no_rsp", 4'b0000, 16'h0000, 1'b0);

        // ch0 reads of freshly cleared words.
        for (int k = 0; k < 4; k++) begin
            idle();
            set_req(0, 1'b0, AW'(k), '0);
            #1 chk("rd0_gnt", 64'(req_ready), 64'b0001);
            tick();
            chk_rsp("rd0_rsp", 4'b0001, 16'h0000, 1'b0);
        end
        idle();
        tick();
        chk_rsp("idle_rsp", 4'b0000, 16'h0000, 1'b0);

        // Write then immediately read back from another channel (ptr=1 now).
        set_req(0, 1'b1, 12'h010, 16'hBEEF);
        #1 chk("wr_gnt", 64'(req_ready), 64'b0001);
        tick();
        idle();
        set_req(1, 1'b0, 12'h010, '0);
        chk_rsp("wr_ack", 4'b0001, 16'h0000, 1'b0);
        #1 chk("rdback_gnt", 64'(req_ready), 64'b0010);
        tick();
        idle();
        chk_rsp("rdback", 4'b0010, 16'hBEEF, 1'b0);

        // Out-of-range read and write (ptr=2 now).
        set_req(2, 1'b0, 12'h200, '0);
        #1 chk("oor_rd_gnt", 64'(req_ready), 64'b0100);
        tick();
        idle();
        set_req(3, 1'b1, 12'h3FF, 16'h1234);
        chk_rsp("oor_rd", 4'b0100, 16'h0000, 1'b1);
        #1 chk("oor_wr_gnt", 64'(req_ready), 64'b1000);
        tick();
        idle();
        chk_rsp("oor_wr", 4'b1000, 16'h0000, 1'b1);

        // All four channels valid for 8 cycles (ptr=0 now).
        set_req(0, 1'b0, 12'h010, '0);
        set_req(1, 1'b0, 12'h000, '0);
        set_req(2, 1'b0, 12'h1FF, '0);
        set_req(3, 1'b0, 12'h200, '0);
        exp_d = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_gnt", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk_rsp("rr_rsp", 4'(4'b0001 << (k % 4)), exp_d[k % 4], exp_e[k % 4]);
        end
        idle();
        tick();
        chk_rsp("rr_idle", 4'b0000, 16'h0000, 1'b0);

        // Move ptr to 1, then a lone ch3 request wins immediately and wraps ptr to 0.
        set_req(0, 1'b0, 12'h001, '0);
        #1 chk("ptr1_gnt", 64'(req_ready), 64'b0001);
        tick();
        idle();
        set_req(3, 1'b0, 12'h010, '0);
        chk_rsp("ptr1_rsp", 4'b0001, 16'h0000, 1'b0);
        #1 chk("lone3_gnt", 64'(req_ready), 64'b1000);
        tick();
        idle();
        chk_rsp("lone3_rsp", 4'b1000, 16'hBEEF, 1'b0);
        req_valid = 4'hF;
        #1 chk("ptr_wrap_gnt", 64'(req_ready), 64'b0001);
        idle();

        // Reset right after a read is accepted: response dropped, memory re-cleared.
        set_req(0, 1'b0, 12'h010, '0);
        #1 chk("pre_rst_gnt", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        #1;
        chk_rsp("midrst", 4'b0000, 16'h0000, 1'b0);
        chk("midrst_ready", 64'(ready), 64'd0);
        tick();
        reset     = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 511; i++) begin
            tick();
            seen_busy = seen_busy | (ready !== 1'b0);
        end
        chk("reinit_hold", 64'(seen_busy), 64'd0);
        tick();
        chk("reinit_ready", 64'(ready), 64'd1);
        set_req(0, 1'b0, 12'h010, '0);
        #1 chk("reinit_gnt", 64'(req_ready), 64'b0001);
        tick();
        idle();
        chk_rsp("reinit_rd", 4'b0001, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
